// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
//   rx_state_t : receiver FSM states
//   PAR_EVEN / PAR_ODD : parity-mode encodings for the PARITY_ODD parameter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata: write request and data; accepted when not full or when a pop
//                happens in the same cycle
//   pop        : advance the head; ignored while empty
//   rdata      : head entry, forced to 0 while empty
//   full, empty, count : occupancy status
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate its contents,
  // and leaving it reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead FIFO.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   baud_tick    : OVERSAMPLE pulses per bit period; all sampling happens on it
//   rx_enable    : receiver enable; dropping it aborts a frame in progress
//   rx           : asynchronous serial input, idles high
//   rx_data, rx_perr, rx_ferr, rx_valid, rx_ready : FIFO head and handshake
//   fifo_count   : entries held
//   overrun      : sticky frame-dropped flag, cleared by overrun_clr
//   break_det    : one-clk pulse when an all-zero frame with a framing error ends
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        baud_tick,
  input  logic                        rx_enable,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic                        break_det
);

  localparam int             TW        = $clog2(OVERSAMPLE);
  localparam int             BW        = $clog2(DATA_BITS);
  localparam int             W         = DATA_BITS + 2;
  localparam logic [TW-1:0]  TICK_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);

  logic                 rx_meta, rx_s;
  rx_state_t            state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 armed, armed_n;
  logic                 frame_done;
  logic                 frame_ferr;
  logic                 fifo_full, fifo_empty;
  logic [W-1:0]         head;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      armed    <= armed_n;
    end
  end

  // Framing error includes the stop sample being taken this tick.
  assign frame_ferr = ferr | ~rx_s;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    perr_n     = perr;
    ferr_n     = ferr;
    armed_n    = armed;
    frame_done = 1'b0;

    if (state != IDLE && !rx_enable) begin
      state_n = IDLE;
      tick_n  = '0;
      bit_n   = '0;
      perr_n  = 1'b0;
      ferr_n  = 1'b0;
      armed_n = 1'b0;
    end else if (baud_tick) begin
      unique case (state)
        IDLE: begin
          // A start bit is only accepted once the line has been seen high,
          // so a held break does not retrigger.
          if (rx_s) begin
            armed_n = 1'b1;
          end else if (armed && rx_enable) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_HALF) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_n   = '0;
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            perr_n  = ((^shreg) ^ rx_s) != (PARITY_ODD == PAR_ODD);
            state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n = '0;
            ferr_n = frame_ferr;
            if (bit_cnt == STOP_LAST) begin
              bit_n      = '0;
              frame_done = 1'b1;
              armed_n    = 1'b0;
              state_n    = IDLE;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Overrun set wins over clear; the drop condition mirrors the FIFO's
  // acceptance rule (a same-cycle pop makes room).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (frame_done && fifo_full && !(rx_ready && !fifo_empty)) overrun <= 1'b1;
      else if (overrun_clr)                                     overrun <= 1'b0;
      break_det <= frame_done && (shreg == '0) && frame_ferr;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (frame_done),
    .wdata ({frame_ferr, perr, shreg}),
    .pop   (rx_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rx_data  = head[DATA_BITS-1:0];
  assign rx_perr  = head[DATA_BITS];
  assign rx_ferr  = head[DATA_BITS+1];
  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: baud_tick held high (16 clk per bit).
// dut uses default parameters; dut_p enables even parity.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, baud_tick, rx_enable, rx, rx_p, rx_ready, rx_ready_p, overrun_clr;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_perr, rx_ferr, rx_valid, overrun, break_det;
  logic       rx_perr_p, rx_ferr_p, rx_valid_p, overrun_p, break_det_p;
  logic [3:0] fifo_count, fifo_count_p;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cyc0, rise_cyc, valid_cnt, brk_cnt;
  logic prev_valid = 1'b0;
  logic [9:0] got[$];
  logic [9:0] got_p[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_enable(rx_enable), .rx(rx),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .overrun(overrun),
    .overrun_clr(overrun_clr), .break_det(break_det)
  );

  uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(PAR_EVEN)) dut_p (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_enable(rx_enable), .rx(rx_p),
    .rx_data(rx_data_p), .rx_perr(rx_perr_p), .rx_ferr(rx_ferr_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .fifo_count(fifo_count_p), .overrun(overrun_p),
    .overrun_clr(overrun_clr), .break_det(break_det_p)
  );

  // Observe outputs mid-cycle: record accepted entries, rx_valid rises, break pulses.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_valid) valid_cnt++;
    if (rx_valid && rx_ready) got.push_back({rx_ferr, rx_perr, rx_data});
    if (break_det) brk_cnt++;
    if (rx_valid_p && rx_ready_p) got_p.push_back({rx_ferr_p, rx_perr_p, rx_data_p});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] entry(input int i);
    return (i < got.size()) ? got[i] : 10'h3ff;
  endfunction

  function automatic logic [9:0] entry_p(input int i);
    return (i < got_p.size()) ? got_p[i] : 10'h3ff;
  endfunction

  task automatic send_bit(input bit sel, input logic b);
    if (sel) rx_p = b;
    else     rx   = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, d[i]);
    send_bit(1'b0, 1'b1);
  endtask

  task automatic send_frame_p(input logic [7:0] d, input logic par);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, d[i]);
    send_bit(1'b1, par);
    send_bit(1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; baud_tick = 1'b1; rx_enable = 1'b1; rx = 1'b1; rx_p = 1'b1;
    rx_ready = 1'b1; rx_ready_p = 1'b1; overrun_clr = 1'b0;
    valid_cnt = 0; brk_cnt = 0; rise_cyc = -1;
    idle(3);

    // Reset state
    check("rst_valid",   32'(rx_valid),   32'd0);
    check("rst_data",    32'(rx_data),    32'd0);
    check("rst_flags",   32'({rx_perr, rx_ferr}), 32'd0);
    check("rst_count",   32'(fifo_count), 32'd0);
    check("rst_overrun", 32'(overrun),    32'd0);
    check("rst_break",   32'(break_det),  32'd0);
    check("rst_state",   32'(dut.state),  32'(IDLE));
    rst_n = 1'b1;
    idle(20);

    // 1: single frame 0xA5, latency 2 sync + 1 detect + 8 + 9*16 = 155 clk
    got.delete(); valid_cnt = 0;
    cyc0 = cyc;
    send_frame(8'hA5);
    idle(20);
    check("t1_size",    32'(got.size()), 32'd1);
    check("t1_entry",   32'(entry(0)), 32'h0A5);
    check("t1_vlen",    32'(valid_cnt), 32'd1);
    check("t1_latency", 32'(rise_cyc - cyc0), 32'd155);
    check("t1_count",   32'(fifo_count), 32'd0);

    // 2: even parity, 0x07 has three ones
    send_frame_p(8'h07, 1'b1);
    send_frame_p(8'h07, 1'b0);
    idle(20);
    check("t2_size",   32'(got_p.size()), 32'd2);
    check("t2_good",   32'(entry_p(0)), 32'h007);
    check("t2_bad",    32'(entry_p(1)), 32'h107);

    // 3: overflow with consumer stalled
    rx_ready = 1'b0; got.delete();
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    idle(10);
    check("t3_count",   32'(fifo_count), 32'd8);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_head",    32'(rx_data), 32'h01);
    check("t3_valid",   32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    idle(10);
    rx_ready = 1'b0;
    check("t3_popped", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t3_order", 32'(entry(i)), 32'(i + 1));
    check("t3_empty",       32'(fifo_count), 32'd0);
    check("t3_ovr_sticky",  32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'd0);

    // 4: glitch then break
    rx_ready = 1'b1; got.delete(); brk_cnt = 0;
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(40);
    check("t4_glitch_push",  32'(got.size()), 32'd0);
    check("t4_glitch_state", 32'(dut.state), 32'(IDLE));
    rx = 1'b0; idle(12 * 16);
    check("t4_brk_size",  32'(got.size()), 32'd1);
    check("t4_brk_entry", 32'(entry(0)), 32'h200);
    check("t4_brk_pulse", 32'(brk_cnt), 32'd1);
    check("t4_held_idle", 32'(dut.state), 32'(IDLE));
    rx = 1'b1; idle(40);
    check("t4_no_rearm", 32'(got.size()), 32'd1);
    check("t4_brk_once", 32'(brk_cnt), 32'd1);

    // 5: push into a full FIFO in the same cycle as a pop
    rx_ready = 1'b0; got.delete();
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i));
    check("t5_full", 32'(fifo_count), 32'd8);
    fork
      send_frame(8'h19);
      begin
        idle(154);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(5);
    check("t5_count",   32'(fifo_count), 32'd8);
    check("t5_overrun", 32'(overrun), 32'd0);
    check("t5_popped",  32'(entry(0)), 32'h011);
    check("t5_head",    32'(rx_data), 32'h12);
    rx_ready = 1'b1;
    idle(12);
    check("t5_drain", 32'(got.size()), 32'd9);
    check("t5_last",  32'(entry(8)), 32'h019);

    // 6a: rx_enable dropped during data bit 3
    got.delete();
    fork
      send_frame(8'hA5);
      begin
        idle(16 * 4 + 8);
        check("t6_in_data", 32'(dut.state), 32'(DATA));
        rx_enable = 1'b0;
        idle(2);
        check("t6_abort_state", 32'(dut.state), 32'(IDLE));
      end
    join
    rx_enable = 1'b1;
    idle(20);
    send_frame(8'h3C);
    idle(20);
    check("t6_en_size",  32'(got.size()), 32'd1);
    check("t6_en_entry", 32'(entry(0)), 32'h03C);

    // 6b: reset mid-frame with an entry already queued
    rx_ready = 1'b0;
    send_frame(8'h55);
    idle(4);
    check("t6_queued", 32'(fifo_count), 32'd1);
    fork
      send_frame(8'h66);
      begin
        idle(80);
        rst_n = 1'b0;
      end
    join
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    idle(20);
    got.delete(); rx_ready = 1'b1;
    send_frame(8'h3C);
    idle(20);
    check("t6_rst_size",  32'(got.size()), 32'd1);
    check("t6_rst_entry", 32'(entry(0)), 32'h03C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Next-generation UART receiver for the UART-to-I2C bridge. It replaces the fixed 8-bit receiver that ran on a derived uart_clk. The new block runs on the single system clock, samples rx with an oversampling tick from the baud rate generator, and supports configurable data width, parity and stop bits. Received frames, with per-frame error flags, go into an internal FIFO that the I2C command FSM drains through a valid/ready handshake.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
OVERSAMPLE, 16, baud_tick pulses per bit period, even, >= 4
STOP_BITS, 1, stop bits checked, 1 or 2
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN = 1)
FIFO_DEPTH, 8, FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk pulse, OVERSAMPLE pulses per bit period
rx_enable  in  1  receiver enable
rx  in  1  serial input, asynchronous, idles high
rx_data  out  DATA_BITS  FIFO head data (show-ahead)
rx_perr  out  1  parity error flag of the head entry
rx_ferr  out  1  framing error flag of the head entry
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts the head entry
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overrun  out  1  sticky: a frame was dropped because the FIFO was full
overrun_clr  in  1  clears overrun
break_det  out  1  one-clk pulse: break received

Behaviour:
- Reset values: all outputs 0, except rx_data, which is 0 via the empty FIFO head. The synchroniser flops reset to 1. State is IDLE and all counters are 0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s and change only on clk edges where baud_tick = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_enable = 1 and rx_s = 0 on a tick, go to START with tick_cnt = 0.
- START: count OVERSAMPLE/2 - 1 ticks, then sample mid-bit.
  - rx_s = 1: glitch; return to IDLE with no push.
  - rx_s = 0: go to DATA with tick_cnt = 0 and bit_cnt = 0.
- DATA: sample every OVERSAMPLE ticks, LSB first, shifting into shreg. After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else go to STOP.
- PARITY: take one sample. perr = (XOR of data bits XOR sampled bit) != PARITY_ODD. When PARITY_EN = 0, perr = 0.
- STOP: take STOP_BITS samples. Any sample equal to 0 sets ferr.
- On the final stop sample tick: push {ferr, perr, data} and go to IDLE.
  - If the data is all 0 and ferr = 1, also pulse break_det for one clk. The frame is still pushed.
  - IDLE re-arms only after rx_s returns to 1, so a held break is not re-detected as a new start bit.
- rx_enable deasserted in any non-IDLE state: abort to IDLE on the next clk edge, no push, flags discarded.
- FIFO rules:
  - Write occurs on the final stop sample edge. rx_valid rises on the next clk.
  - Pop happens when rx_valid & rx_ready. The head advances on that edge.
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the frame is dropped and overrun is set.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_ready while empty is ignored.
- overrun: set has priority over overrun_clr in the same cycle.
- Reset mid-frame: the FSM returns to IDLE immediately and the FIFO empties.

Decomposition:
- Package uart_pkg: rx_state_t enum (IDLE, START, DATA, PARITY, STOP), and the parity-mode localparams PAR_EVEN = 0 and PAR_ODD = 1.
- Sub-module sync_fifo, parameterised by WIDTH = DATA_BITS+2 and DEPTH = FIFO_DEPTH, with outputs full, empty and count.
- The FSM and sampling logic stay in uart_rx_fifo.

Test Plan:
1. Defaults, baud_tick tied to 1 (16 clk per bit), rx_ready = 1, send 0xA5 -> rx_valid for exactly 1 clk with rx_data = 0xA5, perr = 0, ferr = 0; rx_valid rises 1 clk after the final stop sample.
2. PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first frame perr = 0, second frame perr = 1.
3. rx_ready = 0, send 9 frames 0x01..0x09 (FIFO_DEPTH = 8) -> fifo_count = 8, overrun = 1, head = 0x01. After 8 pops the data is 0x01..0x08, and 0x09 is absent.
4. rx low for 4 ticks then high (glitch) -> no push, FSM back in IDLE. Next, rx low for 12 bit periods -> one push with data 0x00, ferr = 1, one break_det pulse, and no second frame until rx returns high.
5. FIFO at count 8, with a frame completing in the same cycle as a pop -> push accepted, count stays 8, overrun stays 0.
6. rx_enable dropped during DATA bit 3, or rst_n asserted mid-frame -> no push; the next full frame 0x3C is received correctly.
